load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage directly downstream of the ALU: takes the ALU result as the effective address
//  plus rs2 store data, and runs one load or store per request on a single-outstanding
//  req/gnt/rvalid data bus. Stores get byte-lane alignment; loads get extraction and sign/zero
//  extension. Misaligned/illegal accesses and bus timeouts are flagged; writeback gets a 1-cycle done.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in REQ+WAIT_R before abort with err (1..255, 8-bit counter)
// PORTS
//  clk         in   1   single clock, all state on rising edge
//  rst_n       in   1   synchronous, active-low reset
//  start       in   1   request strobe from execute; sampled only in IDLE
//  is_load     in   1   request is a load
//  is_store    in   1   request is a store
//  funct3      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  addr        in   32  effective address (ALU ADD result)
//  store_data  in   32  rs2 value
//  busy        out  1   high in every state except IDLE
//  done        out  1   1-cycle pulse, transaction finished (ok or err)
//  err         out  1   valid with done: misaligned, illegal funct3, or timeout
//  load_data   out  32  extended load result; valid with done & ~err, held until next done
//  mem_req     out  1   bus request; held high until mem_gnt
//  mem_we      out  1   1 = write
//  mem_addr    out  32  word-aligned address {addr[31:2],2'b00}
//  mem_wdata   out  32  lane-replicated store data
//  mem_be      out  4   byte enables
//  mem_gnt     in   1   request accepted this cycle
//  mem_rvalid  in   1   read data valid
//  mem_rdata   in   32  read data word
// BEHAVIOUR
//  - Reset: state IDLE; busy, done, err, mem_req, mem_we = 0; load_data, mem_addr, mem_wdata,
//    mem_be = 0; timeout counter 0. Reset mid-transaction aborts it; no done is produced.
//  - FSM IDLE -> REQ -> (WAIT_R) -> DONE -> IDLE.
//  - IDLE: start with exactly one of is_load/is_store latches addr, store_data, funct3, kind.
//    start with both or neither set is ignored.
//    Misaligned (H/HU with addr[0]=1; W with addr[1:0]!=0) or illegal funct3 (011,110,111 any;
//    100,101 on store) -> DONE with err=1, no bus activity. Otherwise -> REQ.
//  - REQ: mem_req=1 with mem_we/addr/wdata/be stable until mem_gnt. On gnt: store -> DONE,
//    load -> WAIT_R. mem_req drops the cycle after gnt.
//  - WAIT_R: mem_rvalid is honoured only in WAIT_R (never in the gnt cycle); on rvalid capture
//    extracted data into load_data -> DONE.
//  - Timeout: counter clears on entering REQ, increments each REQ/WAIT_R cycle; at TIMEOUT_CYCLES
//    -> DONE with err=1, mem_req low next cycle, late gnt/rvalid ignored.
//  - DONE: done=1 for one cycle -> IDLE. start in DONE or any busy state is ignored (not queued).
//  - Latency: zero-wait store done 2 cycles after start; zero-wait load (gnt in first REQ cycle,
//    rvalid next) done 3 cycles after start.
//  - Store align: SB wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0]; SH wdata={2{d[15:0]}},
//    be=4'b0011<<addr[1:0]; SW wdata=d, be=4'b1111. Loads: be=4'b1111, mem_we=0.
//  - Load extract: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16];
//    B/H sign-extend, BU/HU zero-extend, W as-is.
//  - err=0 on successful done; load_data unchanged on err or store.
// STRUCTURE
//  - Shared package/include riscv_pkg: funct3 load/store constants (F3_B..F3_HU), LSU state encoding.
//  - One sub-module: lsu_align (combinational) - store lane replication/be generation and load
//    extraction/extension; FSM, latches and timeout counter stay in load_store_unit.
// TESTING
//  - SW addr=0x100, data=0xDEADBEEF, gnt 1st REQ cycle -> mem_addr=0x100, be=1111,
//    wdata=0xDEADBEEF, done 2 cycles after start, err=0.
//  - LB addr=0x203, rdata=0x80FF_1234 -> be=1111, load_data=0xFFFFFF80; LBU same -> 0x00000080.
//  - SH addr=0x102, data=0x0000ABCD -> mem_addr=0x100, be=1100, wdata=0xABCDABCD;
//    LH addr=0x101 -> done+err=1, mem_req never asserted.
//  - LW, gnt after 3 stall cycles, rvalid 2 cycles later, rdata=0x12345678 -> req held stable
//    throughout, load_data=0x12345678; start pulses while busy ignored.
//  - TIMEOUT_CYCLES=8, mem_gnt tied 0 -> done+err=1 at count 8, mem_req low next cycle.
//  - rst_n low during WAIT_R -> next cycle IDLE, all outputs 0, no done; later rvalid ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V memory-stage definitions: funct3 access-size codes, the
// load/store unit state encoding, and the access legality check.
package riscv_pkg;

  // funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Load/store unit FSM states
  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_REQ    = 2'd1,
    LSU_WAIT_R = 2'd2,
    LSU_DONE   = 2'd3
  } lsu_state_e;

  // True when the access must be rejected without touching the bus:
  // unknown funct3, unsigned sizes on a store, or a misaligned H/HU/W.
  function automatic logic lsu_access_err(input logic [2:0] funct3,
                                          input logic       is_load,
                                          input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = addr_lo[0];
      F3_W:    bad = (addr_lo != 2'b00);
      F3_BU:   bad = !is_load;
      F3_HU:   bad = !is_load || addr_lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Single-outstanding req/gnt/rvalid data bus between the load/store unit
// (master) and the data memory or interconnect (slave).
interface load_store_unit_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for the load/store unit: store data
// replication plus byte enables, and load extraction with sign/zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_wdata_o,
  output logic [3:0]  st_be_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store side: replicate the low byte/half across all lanes, enable only the addressed ones
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    st_wdata_o = st_data_i;
    st_be_o    = 4'b1111;
    case (st_funct3_i)
      F3_B: begin
        st_wdata_o = {4{st_data_i[7:0]}};
        st_be_o    = 4'b0001 << st_addr_lo_i;
      end
      F3_H: begin
        st_wdata_o = {2{st_data_i[15:0]}};
        st_be_o    = 4'b0011 << st_addr_lo_i;
      end
      default: ;
    endcase
  end

  // Load side: pick the addressed byte/half and extend it to 32 bits
  always_comb begin
    ld_byte   = ld_rdata_i[{ld_addr_lo_i, 3'b000} +: 8];
    ld_half   = ld_rdata_i[{ld_addr_lo_i[1], 4'b0000} +: 16];
    ld_data_o = ld_rdata_i;
    case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_data_o = {24'd0, ld_byte};
      F3_HU:   ld_data_o = {16'd0, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage after the ALU: runs one load or store per request on a
// single-outstanding req/gnt/rvalid bus, flags illegal/misaligned accesses
// and bus timeouts, and pulses done for one cycle to writeback.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               is_load,
  input  logic               is_store,
  input  logic [2:0]         funct3,
  input  logic [31:0]        addr,
  input  logic [31:0]        store_data,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [31:0]        load_data,
  load_store_unit_if.master  mem
);

  // Counter value seen during the last allowed REQ/WAIT_R cycle
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q;
  logic [1:0]  addr_lo_q;
  logic [2:0]  funct3_q;
  logic        is_load_q;
  logic [7:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] load_data_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_be_q;

  logic        accept;
  logic        access_bad;
  logic        expire;
  logic [31:0] wdata_d;
  logic [3:0]  be_d;
  logic [31:0] load_data_d;

  // Exactly one of load/store must accompany start for the request to count
  assign accept     = start && (is_load ^ is_store);
  assign access_bad = lsu_access_err(funct3, is_load, addr[1:0]);
  assign expire     = (cnt_q == TIMEOUT_LAST);

  // Store lanes come straight from the request inputs so the bus fields are
  // registered on the same edge that raises mem_req; load extraction uses the
  // latched offset and size against the returning read word.
  lsu_align u_align (
    .st_funct3_i  (funct3),
    .st_addr_lo_i (addr[1:0]),
    .st_data_i    (store_data),
    .st_wdata_o   (wdata_d),
    .st_be_o      (be_d),
    .ld_funct3_i  (funct3_q),
    .ld_addr_lo_i (addr_lo_q),
    .ld_rdata_i   (mem.mem_rdata),
    .ld_data_o    (load_data_d)
  );

  // Transaction FSM with registered outputs, timeout counter and request latches
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q     <= LSU_IDLE;
      addr_lo_q   <= 2'b00;
      funct3_q    <= 3'b000;
      is_load_q   <= 1'b0;
      cnt_q       <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'b0000;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        LSU_IDLE: begin
          if (accept) begin
            addr_lo_q <= addr[1:0];
            funct3_q  <= funct3;
            is_load_q <= is_load;
            busy_q    <= 1'b1;
            if (access_bad) begin
              state_q <= LSU_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q     <= LSU_REQ;
              cnt_q       <= 8'd0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {addr[31:2], 2'b00};
              mem_wdata_q <= is_store ? wdata_d : 32'd0;
              mem_be_q    <= is_store ? be_d : 4'b1111;
            end
          end
        end

        LSU_REQ: begin
          cnt_q <= cnt_q + 8'd1;
          // A load granted in its final allowed cycle has no time left for rvalid
          if (mem.mem_gnt && !(is_load_q && expire)) begin
            mem_req_q <= 1'b0;
            if (is_load_q) begin
              state_q <= LSU_WAIT_R;
            end else begin
              state_q <= LSU_DONE;
              done_q  <= 1'b1;
            end
          end else if (expire) begin
            mem_req_q <= 1'b0;
            state_q   <= LSU_DONE;
            done_q    <= 1'b1;
            err_q     <= 1'b1;
          end
        end

        LSU_WAIT_R: begin
          cnt_q <= cnt_q + 8'd1;
          if (mem.mem_rvalid) begin
            load_data_q <= load_data_d;
            state_q     <= LSU_DONE;
            done_q      <= 1'b1;
          end else if (expire) begin
            state_q <= LSU_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end

        LSU_DONE: begin
          state_q <= LSU_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= LSU_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign load_data     = load_data_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_be    = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected completions
// and bus requests; independent monitors pop and compare them.
module tb_load_store_unit;
  import riscv_pkg::*;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'd0;
  logic [31:0] store_data = 32'd0;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] load_data;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .load_data  (load_data),
    .mem        (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] ld;
    int          cyc;
  } done_exp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_exp_t;

  done_exp_t   done_q[$];
  bus_exp_t    bus_q[$];
  logic [31:0] model_ld = 32'd0;
  int          req_cycles = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Completion monitor: every done must match the oldest expected completion
  initial begin
    done_exp_t de;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 72'(done), 72'd0);
        end else begin
          de = done_q.pop_front();
          check("done_err", 72'(err), 72'(de.err));
          check("load_data", 72'(load_data), 72'(de.ld));
          check("done_cycle", 72'(cyc), 72'(de.cyc));
        end
      end
    end
  end

  // Bus monitor: accepted requests against expectations, request held stable, drop after gnt
  initial begin
    bus_exp_t    bx;
    logic        prev_req = 1'b0;
    logic        prev_gnt = 1'b0;
    logic [71:0] prev_bus = 72'd0;
    logic [71:0] cur_bus;
    forever begin
      @(negedge clk);
      cur_bus = {3'b000, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata};
      if (bus.mem_req === 1'b1) req_cycles++;
      if (prev_req && prev_gnt) check("req_drop_after_gnt", 72'(bus.mem_req), 72'd0);
      else if (prev_req && bus.mem_req === 1'b1) check("req_stable", cur_bus, prev_bus);
      if (bus.mem_req === 1'b1 && bus.mem_gnt === 1'b1) begin
        if (bus_q.size() == 0) begin
          check("unexpected_bus_req", 72'(bus.mem_req), 72'd0);
        end else begin
          bx = bus_q.pop_front();
          check("mem_we", 72'(bus.mem_we), 72'(bx.we));
          check("mem_be", 72'(bus.mem_be), 72'(bx.be));
          check("mem_addr", 72'(bus.mem_addr), 72'(bx.addr));
          if (bx.we) check("mem_wdata", 72'(bus.mem_wdata), 72'(bx.wdata));
        end
      end
      prev_req = (bus.mem_req === 1'b1);
      prev_gnt = (bus.mem_gnt === 1'b1);
      prev_bus = cur_bus;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_idle"}, 72'(busy), 72'd0);
    @(posedge clk); #1;
  endtask

  // One request with a scripted bus response; expectations come from the caller
  task automatic run_txn(input string tag, input logic ld, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input int stall, input int rv_gap, input logic [31:0] rdata,
                         input logic poke, input logic rv_in_gnt, input logic exp_err,
                         input logic [31:0] exp_ld, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata);
    done_exp_t e;
    bus_exp_t  b;
    int        lat;
    @(posedge clk); #1;
    start = 1'b1; is_load = ld; is_store = !ld; funct3 = f3; addr = a; store_data = d;
    if (exp_err) lat = 1;
    else if (ld) lat = 2 + stall + rv_gap;
    else lat = 2 + stall;
    if (ld && !exp_err) model_ld = exp_ld;
    e.err = exp_err; e.ld = model_ld; e.cyc = cyc + lat;
    done_q.push_back(e);
    if (!exp_err) begin
      b.we = !ld; b.be = exp_be; b.addr = {a[31:2], 2'b00}; b.wdata = exp_wdata;
      bus_q.push_back(b);
    end
    @(posedge clk); #1;
    start = 1'b0; is_load = 1'b0; is_store = 1'b0;
    if (!exp_err) begin
      repeat (stall) begin
        if (poke) begin start = 1'b1; is_load = 1'b1; end
        @(posedge clk); #1;
        start = 1'b0; is_load = 1'b0;
      end
      bus.mem_gnt = 1'b1;
      if (rv_in_gnt) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = ~rdata; end
      @(posedge clk); #1;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
      if (ld) begin
        repeat (rv_gap - 1) begin @(posedge clk); #1; end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
      end
    end
    wait_idle(tag);
  endtask

  initial begin
    int t0;
    int r0;
    bus_exp_t b;
    done_exp_t e;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    check("rst_ctrl", 72'({busy, done, err, bus.mem_req, bus.mem_we, bus.mem_be}), 72'd0);
    check("rst_load_data", 72'(load_data), 72'd0);
    check("rst_bus_data", {8'd0, bus.mem_addr, bus.mem_wdata}, 72'd0);

    //      tag     ld    f3     addr          data          st rv rdata         pk   rvg  err   exp_ld        be       wdata
    run_txn("sw",   1'b0, F3_W,  32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'd0,        1'b0, 1'b0, 1'b0, 32'd0,        4'b1111, 32'hDEAD_BEEF);
    run_txn("lb",   1'b1, F3_B,  32'h0000_0203, 32'd0,         0, 1, 32'h80FF_1234, 1'b0, 1'b0, 1'b0, 32'hFFFF_FF80, 4'b1111, 32'd0);
    run_txn("lbu",  1'b1, F3_BU, 32'h0000_0203, 32'd0,         0, 1, 32'h80FF_1234, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 4'b1111, 32'd0);
    run_txn("sh",   1'b0, F3_H,  32'h0000_0102, 32'h0000_ABCD, 0, 0, 32'd0,        1'b0, 1'b0, 1'b0, 32'd0,        4'b1100, 32'hABCD_ABCD);
    r0 = req_cycles;
    run_txn("lh_mis", 1'b1, F3_H, 32'h0000_0101, 32'd0,        0, 0, 32'd0,        1'b0, 1'b0, 1'b1, 32'd0,        4'b0000, 32'd0);
    check("lh_mis_no_req", 72'(req_cycles - r0), 72'd0);
    run_txn("lw_stall", 1'b1, F3_W, 32'h0000_0300, 32'd0,      3, 2, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 4'b1111, 32'd0);
    run_txn("lh",   1'b1, F3_H,  32'h0000_0202, 32'd0,         1, 1, 32'h8001_7FFF, 1'b0, 1'b0, 1'b0, 32'hFFFF_8001, 4'b1111, 32'd0);
    run_txn("lhu",  1'b1, F3_HU, 32'h0000_0200, 32'd0,         0, 3, 32'h8001_FFFE, 1'b0, 1'b0, 1'b0, 32'h0000_FFFE, 4'b1111, 32'd0);
    run_txn("sb",   1'b0, F3_B,  32'h0000_0101, 32'h1234_56A5, 2, 0, 32'd0,        1'b0, 1'b0, 1'b0, 32'd0,        4'b0010, 32'hA5A5_A5A5);
    r0 = req_cycles;
    run_txn("sw_mis", 1'b0, F3_W, 32'h0000_0102, 32'h1111_1111, 0, 0, 32'd0,      1'b0, 1'b0, 1'b1, 32'd0,        4'b0000, 32'd0);
    run_txn("st_bu",  1'b0, F3_BU, 32'h0000_0100, 32'h2222_2222, 0, 0, 32'd0,     1'b0, 1'b0, 1'b1, 32'd0,        4'b0000, 32'd0);
    run_txn("ld_f3_011", 1'b1, 3'b011, 32'h0000_0100, 32'd0,   0, 0, 32'd0,        1'b0, 1'b0, 1'b1, 32'd0,        4'b0000, 32'd0);
    check("illegal_no_req", 72'(req_cycles - r0), 72'd0);

    // start with both or neither kind set is ignored
    start = 1'b1; is_load = 1'b1; is_store = 1'b1; funct3 = F3_W; addr = 32'h0000_0100;
    @(posedge clk); #1;
    check("both_kinds_ignored", 72'(busy), 72'd0);
    is_load = 1'b0; is_store = 1'b0;
    @(posedge clk); #1;
    check("no_kind_ignored", 72'(busy), 72'd0);
    start = 1'b0;
    @(posedge clk); #1;

    // Timeout: gnt never arrives, abort after TMO cycles of REQ
    t0 = cyc; r0 = req_cycles;
    start = 1'b1; is_store = 1'b1; funct3 = F3_W; addr = 32'h0000_0400; store_data = 32'h5555_AAAA;
    e.err = 1'b1; e.ld = model_ld; e.cyc = t0 + int'(TMO) + 1;
    done_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; is_store = 1'b0;
    repeat (TMO) begin @(posedge clk); #1; end
    check("timeout_req_cycles", 72'(req_cycles - r0), 72'(TMO));
    check("timeout_req_low", 72'(bus.mem_req), 72'd0);
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("late_gnt_ignored", 72'({busy, bus.mem_req}), 72'd0);
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
    wait_idle("timeout");

    // Reset during WAIT_R aborts silently; a later rvalid is ignored
    start = 1'b1; is_load = 1'b1; funct3 = F3_W; addr = 32'h0000_0500;
    b.we = 1'b0; b.be = 4'b1111; b.addr = 32'h0000_0500; b.wdata = 32'd0;
    bus_q.push_back(b);
    @(posedge clk); #1;
    start = 1'b0; is_load = 1'b0; bus.mem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.mem_gnt = 1'b0;
    check("pre_reset_busy", 72'(busy), 72'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_ld = 32'd0;
    check("mid_rst_ctrl", 72'({busy, done, err, bus.mem_req, bus.mem_we, bus.mem_be}), 72'd0);
    check("mid_rst_bus_data", {8'd0, bus.mem_addr, bus.mem_wdata}, 72'd0);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'd0;
    @(posedge clk); #1;
    check("post_rst_rvalid_ignored", {39'd0, busy, load_data}, 72'd0);
    repeat (3) @(posedge clk);
    #1;

    check("done_queue_drained", 72'(done_q.size()), 72'd0);
    check("bus_queue_drained", 72'(bus_q.size()), 72'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
